// File: rtl/pipeline_sequencer_pkg.sv
// Shared CPU package: sequencer state encodings, default parameter values and the
// pipeline control bundle.
package pipeline_sequencer_pkg;

  localparam int unsigned RegAddrSizeDef = 5;
  localparam int unsigned CountSizeDef   = 32;
  localparam bit          StartHaltedDef = 1'b1;

  localparam logic [1:0] StRun     = 2'b00;
  localparam logic [1:0] StHalted  = 2'b01;
  localparam logic [1:0] StStep    = 2'b10;
  localparam logic [1:0] StIllegal = 2'b11;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_en;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t PipeFrozen = '{default: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned REG_ADDR_SIZE = RegAddrSizeDef
) (
  input  logic [REG_ADDR_SIZE-1:0] rs,
  input  logic [REG_ADDR_SIZE-1:0] rt,
  input  logic [REG_ADDR_SIZE-1:0] ex_rt,
  input  logic                     ex_mem_read,
  output logic                     stall
);

  // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
  always_comb begin
    stall = ex_mem_read && (ex_rt != '0) && ((ex_rt == rs) || (ex_rt == rt));
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: RUN/HALTED/STEP debug FSM plus stall/flush/bubble steering and a
// cycle counter of enabled pipeline cycles.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned REG_ADDR_SIZE = RegAddrSizeDef,
  parameter int unsigned COUNT_SIZE    = CountSizeDef,
  parameter bit          START_HALTED  = StartHaltedDef
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [REG_ADDR_SIZE-1:0] i_id_rs,
  input  logic [REG_ADDR_SIZE-1:0] i_id_rt,
  input  logic [REG_ADDR_SIZE-1:0] i_ex_rt,
  input  logic                     i_ex_mem_read,
  input  logic                     i_id_jump_or_b,
  input  logic                     i_wb_halt,
  input  logic                     i_halt_req,
  input  logic                     i_step_req,
  input  logic                     i_resume_req,
  output logic                     o_pc_en,
  output logic                     o_if_id_en,
  output logic                     o_if_id_flush,
  output logic                     o_id_ex_bubble,
  output logic                     o_pipe_en,
  output logic [1:0]               o_state,
  output logic                     o_done,
  output logic [COUNT_SIZE-1:0]    o_cycle_count
);

  localparam logic [1:0] ResetState = START_HALTED ? StHalted : StRun;

  logic [1:0]            state_q, state_d;
  logic                  done_q, done_d;
  logic [COUNT_SIZE-1:0] cycle_count_q, cycle_count_d;
  logic                  stall;
  pipe_ctrl_t            ctrl;

  hazard_detect #(
    .REG_ADDR_SIZE(REG_ADDR_SIZE)
  ) u_hazard_detect (
    .rs         (i_id_rs),
    .rt         (i_id_rt),
    .ex_rt      (i_ex_rt),
    .ex_mem_read(i_ex_mem_read),
    .stall      (stall)
  );

  // Stall wins over flush; a pending redirect is re-presented on the retried cycle.
  always_comb begin
    ctrl = PipeFrozen;
    if ((state_q == StRun) || (state_q == StStep)) begin
      ctrl.pipe_en = 1'b1;
      if (stall) begin
        ctrl.id_ex_bubble = 1'b1;
      end else begin
        ctrl.pc_en       = 1'b1;
        ctrl.if_id_en    = 1'b1;
        ctrl.if_id_flush = i_id_jump_or_b;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    case (state_q)
      StRun: begin
        if (i_wb_halt) begin
          state_d = StHalted;
          done_d  = 1'b1;
        end else if (i_halt_req) begin
          state_d = StHalted;
        end
      end
      StStep: begin
        state_d = StHalted;
        if (i_wb_halt) begin
          done_d = 1'b1;
        end
      end
      StHalted: begin
        // Once the program has finished only reset can restart it.
        if (!done_q) begin
          if (i_step_req) begin
            state_d = StStep;
          end else if (i_resume_req) begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StHalted;
    endcase
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (ctrl.pipe_en) begin
      cycle_count_d = cycle_count_q + {{(COUNT_SIZE-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= ResetState;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  always_comb begin
    o_pc_en        = ctrl.pc_en;
    o_if_id_en     = ctrl.if_id_en;
    o_if_id_flush  = ctrl.if_id_flush;
    o_id_ex_bubble = ctrl.id_ex_bubble;
    o_pipe_en      = ctrl.pipe_en;
    o_state        = state_q;
    o_done         = done_q;
    o_cycle_count  = cycle_count_q;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: a default instance (starts halted, 32-bit count) and a
// 4-bit-counter instance starting in RUN, both checked every cycle against a behavioural model.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, id_jump_or_b, wb_halt, halt_req, step_req, resume_req;

  logic        pc_en0, if_id_en0, flush0, bubble0, pipe_en0, done0;
  logic [1:0]  state0;
  logic [31:0] count0;
  logic        pc_en1, if_id_en1, flush1, bubble1, pipe_en1, done1;
  logic [1:0]  state1;
  logic [3:0]  count1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_sequencer u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
    .i_ex_mem_read(ex_mem_read), .i_id_jump_or_b(id_jump_or_b), .i_wb_halt(wb_halt),
    .i_halt_req(halt_req), .i_step_req(step_req), .i_resume_req(resume_req),
    .o_pc_en(pc_en0), .o_if_id_en(if_id_en0), .o_if_id_flush(flush0),
    .o_id_ex_bubble(bubble0), .o_pipe_en(pipe_en0), .o_state(state0), .o_done(done0),
    .o_cycle_count(count0)
  );

  pipeline_sequencer #(
    .REG_ADDR_SIZE(5), .COUNT_SIZE(4), .START_HALTED(1'b0)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
    .i_ex_mem_read(ex_mem_read), .i_id_jump_or_b(id_jump_or_b), .i_wb_halt(wb_halt),
    .i_halt_req(halt_req), .i_step_req(step_req), .i_resume_req(resume_req),
    .o_pc_en(pc_en1), .o_if_id_en(if_id_en1), .o_if_id_flush(flush1),
    .o_id_ex_bubble(bubble1), .o_pipe_en(pipe_en1), .o_state(state1), .o_done(done1),
    .o_cycle_count(count1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state kept as a mode name, count as a plain integer modulo 2**W.
  typedef enum int {MRun, MHalted, MStep} mode_e;
  mode_e           m_mode [2];
  bit              m_done [2];
  longint unsigned m_cnt  [2];
  longint unsigned m_mod  [2] = '{64'h1_0000_0000, 64'd16};
  bit              m_start_halted [2] = '{1'b1, 1'b0};
  bit              m_valid = 1'b0;

  function automatic logic [1:0] mode_code(input mode_e m);
    return (m == MRun) ? 2'd0 : (m == MHalted) ? 2'd1 : 2'd2;
  endfunction

  function automatic bit load_use();
    return ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mode[i] = m_start_halted[i] ? MHalted : MRun;
        m_done[i] = 1'b0;
        m_cnt[i]  = 0;
      end else begin
        if (m_mode[i] != MHalted) m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
        if (m_mode[i] != MHalted && wb_halt) begin
          m_mode[i] = MHalted;
          m_done[i] = 1'b1;
        end else if (m_mode[i] == MStep || (m_mode[i] == MRun && halt_req)) begin
          m_mode[i] = MHalted;
        end else if (m_mode[i] == MHalted && !m_done[i] && step_req) begin
          m_mode[i] = MStep;
        end else if (m_mode[i] == MHalted && !m_done[i] && resume_req) begin
          m_mode[i] = MRun;
        end
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic cmp_dut(input int i, input logic pc, input logic ifid, input logic fl,
                         input logic bub, input logic pe, input logic [1:0] st,
                         input logic dn, input logic [31:0] cnt);
    bit go, st_l;
    go   = (m_mode[i] != MHalted);
    st_l = go && load_use();
    chk($sformatf("dut%0d pc_en", i), 32'(pc), 32'(go && !st_l));
    chk($sformatf("dut%0d if_id_en", i), 32'(ifid), 32'(go && !st_l));
    chk($sformatf("dut%0d if_id_flush", i), 32'(fl), 32'(go && !st_l && id_jump_or_b));
    chk($sformatf("dut%0d id_ex_bubble", i), 32'(bub), 32'(st_l));
    chk($sformatf("dut%0d pipe_en", i), 32'(pe), 32'(go));
    chk($sformatf("dut%0d state", i), 32'(st), 32'(mode_code(m_mode[i])));
    chk($sformatf("dut%0d done", i), 32'(dn), 32'(m_done[i]));
    chk($sformatf("dut%0d cycle_count", i), cnt, 32'(m_cnt[i]));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      cmp_dut(0, pc_en0, if_id_en0, flush0, bubble0, pipe_en0, state0, done0, count0);
      cmp_dut(1, pc_en1, if_id_en1, flush1, bubble1, pipe_en1, state1, done1, 32'(count1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: halt_req = 1'b1;
      1: step_req = 1'b1;
      2: resume_req = 1'b1;
      3: wb_halt = 1'b1;
      default: rst = 1'b1;
    endcase
    tick();
    {halt_req, step_req, resume_req, wb_halt, rst} = '0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    {id_rs, id_rt, ex_rt} = '0;
    {ex_mem_read, id_jump_or_b, wb_halt, halt_req, step_req, resume_req} = '0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset state0", 32'(state0), 32'h1);
    chk("reset state1", 32'(state1), 32'h0);
    chk("reset done0", 32'(done0), 32'h0);
    chk("reset count0", count0, 32'h0);
    chk("reset pipe_en0 halted", 32'(pipe_en0), 32'h0);

    // 4-bit counter instance runs freely and wraps after 16 enabled cycles.
    repeat (15) tick();
    #1;
    chk("wrap count1 at 15", 32'(count1), 32'd15);
    tick();
    #1;
    chk("wrap count1 to 0", 32'(count1), 32'd0);
    chk("halted count0", count0, 32'd0);

    pulse(1);
    chk("step state", 32'(state0), 32'h2);
    chk("step pipe_en", 32'(pipe_en0), 32'h1);
    tick();
    #1;
    chk("after step state", 32'(state0), 32'h1);
    chk("after step count", count0, 32'd1);

    pulse(2);
    chk("resume state", 32'(state0), 32'h0);

    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd3;
    #1;
    chk("load-use pc_en", 32'(pc_en0), 32'h0);
    chk("load-use if_id_en", 32'(if_id_en0), 32'h0);
    chk("load-use bubble", 32'(bubble0), 32'h1);
    tick();
    ex_rt = 5'd0; id_rt = 5'd0; id_rs = 5'd7;
    #1;
    chk("zero-reg pc_en", 32'(pc_en0), 32'h1);
    chk("zero-reg bubble", 32'(bubble0), 32'h0);
    tick();
    ex_rt = 5'd5; id_rs = 5'd5; id_jump_or_b = 1'b1;
    #1;
    chk("stall+branch flush", 32'(flush0), 32'h0);
    tick();
    ex_mem_read = 1'b0;
    #1;
    chk("retry flush", 32'(flush0), 32'h1);
    chk("retry pc_en", 32'(pc_en0), 32'h1);
    tick();
    id_jump_or_b = 1'b0;

    pulse(0);
    chk("halt_req state", 32'(state0), 32'h1);
    chk("halt_req done", 32'(done0), 32'h0);
    pulse(2);
    pulse(3);
    chk("wb_halt state", 32'(state0), 32'h1);
    chk("wb_halt done", 32'(done0), 32'h1);
    pulse(2);
    chk("resume ignored", 32'(state0), 32'h1);
    pulse(1);
    chk("step ignored", 32'(state0), 32'h1);
    pulse(4);
    chk("reset clears done", 32'(done0), 32'h0);
    chk("reset clears count", count0, 32'd0);

    step_req = 1'b1; resume_req = 1'b1;
    tick();
    step_req = 1'b0; resume_req = 1'b0;
    #1;
    chk("step beats resume", 32'(state0), 32'h2);
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
    #1;
    chk("stall in step", 32'(bubble0), 32'h1);
    tick();
    ex_mem_read = 1'b0;

    pulse(1);
    pulse(4);
    chk("reset mid-step", 32'(state0), 32'h1);

    pulse(1);
    pulse(3);
    chk("wb_halt in step done", 32'(done0), 32'h1);
    pulse(4);
    pulse(2);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
